nanorv32_test_monitor: RTL and testbench
========================================

Name: nanorv32_test_monitor

Overview:
Synthesizable end-of-test monitor for nanorv32 simulation and FPGA self-test builds.
- Watches the core's executed PC, the a0 return register and the illegal-instruction flag.
- Decides pass/fail/timeout/stall and reports a registered, sticky verdict with a fail code.
- Sits beside the CPU in the chip top. Benches read its outputs instead of hard-coding checks, and FPGA builds can drive LEDs from it.

Parameters:
DATA_W, 32, width of pc and a0
END_PC, 32'h0000_0100, PC value that marks end of test
PASS_VAL, 32'hCAFF_E000, a0 value at END_PC meaning pass
FAIL_VAL, 32'hDEAD_0000, a0 value at END_PC meaning explicit fail
TIMEOUT_CYCLES, 1000000, RUN cycles before timeout verdict; 0 disables
STALL_CYCLES, 1024, consecutive valid samples with unchanged pc before stall verdict; 0 disables
CNT_W, 32, width of cycle and stall counters

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
en  in  1  start monitoring (level)
pc_valid  in  1  qualifies pc/a0/pc_x this cycle
pc  in  DATA_W  executed PC
a0  in  DATA_W  register x10 value
pc_x  in  1  bench-supplied flag: pc contains X/Z (tie 0 in synthesis)
illegal_instruction  in  1  core illegal-instruction flag
done  out  1  verdict reached (sticky)
pass  out  1  verdict is pass (sticky, only with done)
fail_code  out  3  0 none, 1 FAIL_VAL, 2 unknown a0, 3 illegal instr, 4 pc X, 5 timeout, 6 stall
done_pulse  out  1  one-cycle strobe on verdict
cycles  out  CNT_W  RUN cycle count, frozen at verdict

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; done, pass, done_pulse, fail_code, cycles and stall counter all 0. Reset mid-RUN or in DONE discards the verdict.
- FSM states IDLE, RUN, DONE.
  - IDLE -> RUN on the first posedge with en=1. cycles starts at 0 in the first RUN cycle.
  - RUN -> IDLE if en=0. cycles and stall counter clear; no verdict.
  - RUN -> DONE on the first detected event.
  - DONE is terminal until reset; en ignored.
- RUN: cycles increments by 1 each cycle, saturating at all-ones.
- Events are evaluated combinationally on RUN-cycle inputs, highest priority first:
  1. illegal_instruction=1 (pc_valid not required) -> code 3
  2. pc_valid & pc_x -> code 4
  3. pc_valid & pc==END_PC:
     - a0==PASS_VAL -> pass, code 0
     - a0==FAIL_VAL -> code 1
     - else -> code 2
  4. Stall: stall counter == STALL_CYCLES-1 and the current sample is valid with pc equal to the last valid pc -> code 6
  5. Timeout: cycles == TIMEOUT_CYCLES-1 -> code 5
- Verdict timing: done, pass, fail_code and done_pulse update at the posedge ending the event cycle (latency 1). done_pulse is high for exactly that one cycle. cycles holds the value of the event cycle.
- Stall counter:
  - Tracks the last valid pc register.
  - On pc_valid with pc equal to the last pc: counter increments.
  - On pc_valid with a different pc: counter clears and the last pc is updated.
  - Invalid cycles leave the counter unchanged.
  - The first valid sample after entering RUN always loads the last pc and clears the counter.
- Disabled checks: TIMEOUT_CYCLES=0 or STALL_CYCLES=0 suppresses that check entirely.
- Simultaneous events: only the highest-priority code is reported. END_PC with PASS_VAL in the same cycle as timeout -> pass.
- pass=1 implies fail_code=0. done=0 implies pass=0 and fail_code=0.
- Width: compares use full DATA_W; counters are CNT_W bits. TIMEOUT_CYCLES and STALL_CYCLES must fit in CNT_W (elaboration-time check).

Test Plan:
- Pass: en=1, pc steps 0x0,0x4,... up to 0x100 with a0=0xCAFFE000 at cycle 40 -> done=1, pass=1, fail_code=0, done_pulse one cycle, cycles=40.
- Explicit and unknown fail: pc=0x100 with a0=0xDEAD0000 -> fail_code=1. Rerun after reset with a0=0x12345678 -> fail_code=2, pass=0.
- Priority: illegal_instruction=1 and pc=0x100/a0=PASS_VAL in the same cycle -> fail_code=3, pass=0. pc_x=1 with pc_valid=0 -> no event.
- Timeout: TIMEOUT_CYCLES=50, pc toggling 0x10/0x14 -> done at the posedge ending cycle 49, fail_code=5, cycles=49. TIMEOUT_CYCLES=0 -> never done in 10000 cycles.
- Stall: STALL_CYCLES=8, pc held at 0x20 valid every cycle -> fail_code=6 on the 9th identical sample. Interleaved pc_valid=0 cycles extend the time without resetting the count.
- Reset and en: rst_n=0 in DONE -> all outputs 0 next cycle. en dropped mid-RUN at cycle 20 -> IDLE, cycles=0. Re-enable then pass -> cycles counts from 0.

Source files
------------

// File: rtl/nanorv32_test_monitor.sv
// End-of-test monitor for nanorv32: watches executed PC, a0 and the illegal flag,
// and latches a sticky pass/fail verdict with a fail code and the RUN cycle count.
module nanorv32_test_monitor #(
    parameter int unsigned           DATA_W         = 32,
    parameter logic [DATA_W-1:0]     END_PC         = 32'h0000_0100,
    parameter logic [DATA_W-1:0]     PASS_VAL       = 32'hCAFF_E000,
    parameter logic [DATA_W-1:0]     FAIL_VAL       = 32'hDEAD_0000,
    parameter longint unsigned       TIMEOUT_CYCLES = 1000000,
    parameter longint unsigned       STALL_CYCLES   = 1024,
    parameter int unsigned           CNT_W          = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              pc_valid,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] a0,
    input  logic              pc_x,
    input  logic              illegal_instruction,
    output logic              done,
    output logic              pass,
    output logic [2:0]        fail_code,
    output logic              done_pulse,
    output logic [CNT_W-1:0]  cycles
);

    localparam longint unsigned CNT_MAX = (CNT_W >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                        : ((64'd1 << CNT_W) - 64'd1);
    localparam bit             TO_EN      = (TIMEOUT_CYCLES != 0);
    localparam bit             STALL_EN   = (STALL_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 64'd1);
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_CYCLES - 64'd1);

    localparam logic [2:0] CODE_NONE    = 3'd0;
    localparam logic [2:0] CODE_FAILVAL = 3'd1;
    localparam logic [2:0] CODE_UNKNOWN = 3'd2;
    localparam logic [2:0] CODE_ILLEGAL = 3'd3;
    localparam logic [2:0] CODE_PCX     = 3'd4;
    localparam logic [2:0] CODE_TIMEOUT = 3'd5;
    localparam logic [2:0] CODE_STALL   = 3'd6;

    if (TIMEOUT_CYCLES > CNT_MAX || STALL_CYCLES > CNT_MAX) begin : g_cnt_w_check
        $error("TIMEOUT_CYCLES/STALL_CYCLES do not fit in CNT_W bits");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [DATA_W-1:0] last_pc_q, last_pc_d;
    logic              last_pc_vld_q, last_pc_vld_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [2:0]        code_q, code_d;
    logic              pulse_q, pulse_d;

    logic              same_pc;
    logic              ev;
    logic              ev_pass;
    logic [2:0]        ev_code;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Event detection in priority order; only meaningful while in RUN.
    always_comb begin
        same_pc = pc_valid && last_pc_vld_q && (pc == last_pc_q);
        ev      = 1'b0;
        ev_pass = 1'b0;
        ev_code = CODE_NONE;
        if (illegal_instruction) begin
            ev      = 1'b1;
            ev_code = CODE_ILLEGAL;
        end else if (pc_valid && pc_x) begin
            ev      = 1'b1;
            ev_code = CODE_PCX;
        end else if (pc_valid && (pc == END_PC)) begin
            ev = 1'b1;
            if (a0 == PASS_VAL)      ev_pass = 1'b1;
            else if (a0 == FAIL_VAL) ev_code = CODE_FAILVAL;
            else                     ev_code = CODE_UNKNOWN;
        end else if (STALL_EN && same_pc && (stall_cnt_q == STALL_LAST)) begin
            ev      = 1'b1;
            ev_code = CODE_STALL;
        end else if (TO_EN && (cycles_q == TO_LAST)) begin
            ev      = 1'b1;
            ev_code = CODE_TIMEOUT;
        end
    end

    always_comb begin
        state_d       = state_q;
        cycles_d      = cycles_q;
        stall_cnt_d   = stall_cnt_q;
        last_pc_d     = last_pc_q;
        last_pc_vld_d = last_pc_vld_q;
        done_d        = done_q;
        pass_d        = pass_q;
        code_d        = code_q;
        pulse_d       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cycles_d      = '0;
                stall_cnt_d   = '0;
                last_pc_vld_d = 1'b0;
                if (en) state_d = S_RUN;
            end
            S_RUN: begin
                if (!en) begin
                    state_d       = S_IDLE;
                    cycles_d      = '0;
                    stall_cnt_d   = '0;
                    last_pc_vld_d = 1'b0;
                end else if (ev) begin
                    // cycles is left at the event-cycle value from here on
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = ev_pass;
                    code_d  = ev_code;
                    pulse_d = 1'b1;
                end else begin
                    cycles_d = sat_inc(cycles_q);
                    if (pc_valid) begin
                        if (same_pc) begin
                            stall_cnt_d = sat_inc(stall_cnt_q);
                        end else begin
                            stall_cnt_d   = '0;
                            last_pc_d     = pc;
                            last_pc_vld_d = 1'b1;
                        end
                    end
                end
            end
            S_DONE: ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cycles_q      <= '0;
            stall_cnt_q   <= '0;
            last_pc_vld_q <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            code_q        <= CODE_NONE;
            pulse_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cycles_q      <= cycles_d;
            stall_cnt_q   <= stall_cnt_d;
            last_pc_vld_q <= last_pc_vld_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            code_q        <= code_d;
            pulse_q       <= pulse_d;
        end
    end

    // Last-pc data needs no reset: it is qualified by last_pc_vld_q.
    always_ff @(posedge clk) begin
        last_pc_q <= last_pc_d;
    end

    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_code  = code_q;
    assign done_pulse = pulse_q;
    assign cycles     = cycles_q;

endmodule

// File: tb/tb_nanorv32_test_monitor.sv
// Directed bench for nanorv32_test_monitor: one instance with short timeout/stall limits,
// one with both checks disabled, driven from shared inputs.
module tb_nanorv32_test_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        pc_valid;
    logic [31:0] pc;
    logic [31:0] a0;
    logic        pc_x;
    logic        illegal_instruction;

    logic        d0, p0, dp0, d1, p1, dp1;
    logic [2:0]  c0, c1;
    logic [31:0] cy0, cy1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nanorv32_test_monitor #(.TIMEOUT_CYCLES(50), .STALL_CYCLES(8)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .pc_valid(pc_valid), .pc(pc), .a0(a0),
        .pc_x(pc_x), .illegal_instruction(illegal_instruction),
        .done(d0), .pass(p0), .fail_code(c0), .done_pulse(dp0), .cycles(cy0)
    );

    nanorv32_test_monitor #(.TIMEOUT_CYCLES(0), .STALL_CYCLES(0)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .pc_valid(pc_valid), .pc(pc), .a0(a0),
        .pc_x(pc_x), .illegal_instruction(illegal_instruction),
        .done(d1), .pass(p1), .fail_code(c1), .done_pulse(dp1), .cycles(cy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; pc_valid = 1'b0; pc = '0; a0 = '0;
        pc_x = 1'b0; illegal_instruction = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic start_run();
        en = 1'b1;
        tick();
    endtask

    initial begin
        logic seen;
        do_reset();
        tick();
        check("reset_done", d0, 0);
        check("reset_pass", p0, 0);
        check("reset_code", c0, 0);
        check("reset_pulse", dp0, 0);
        check("reset_cycles", cy0, 0);

        // Pass at RUN cycle 40
        start_run();
        check("run_start_cycles", cy0, 0);
        pc_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            pc = 32'(4 * k);
            tick();
        end
        check("pass_pre_done", d0, 0);
        check("pass_pre_cycles", cy0, 40);
        pc = 32'h100; a0 = 32'hCAFF_E000;
        tick();
        check("pass_done", d0, 1);
        check("pass_pass", p0, 1);
        check("pass_code", c0, 0);
        check("pass_pulse", dp0, 1);
        check("pass_cycles", cy0, 40);
        pc = 32'h104; a0 = 0; illegal_instruction = 1'b1;
        tick();
        check("pass_pulse_drop", dp0, 0);
        check("pass_sticky_done", d0, 1);
        check("pass_sticky_code", c0, 0);
        check("pass_frozen_cycles", cy0, 40);

        // Reset while in DONE clears everything
        rst_n = 1'b0;
        tick();
        check("rst_done_done", d0, 0);
        check("rst_done_pass", p0, 0);
        check("rst_done_cycles", cy0, 0);

        // Explicit fail
        do_reset(); start_run();
        pc_valid = 1'b1; pc = 32'h100; a0 = 32'hDEAD_0000;
        tick();
        check("explicit_fail_code", c0, 1);
        check("explicit_fail_pass", p0, 0);
        check("explicit_fail_done", d0, 1);

        // Unknown a0 at END_PC
        do_reset(); start_run();
        pc_valid = 1'b1; pc = 32'h100; a0 = 32'h1234_5678;
        tick();
        check("unknown_code", c0, 2);
        check("unknown_pass", p0, 0);

        // Illegal beats a passing END_PC sample
        do_reset(); start_run();
        pc_valid = 1'b1; pc = 32'h100; a0 = 32'hCAFF_E000; illegal_instruction = 1'b1;
        tick();
        check("prio_illegal_code", c0, 3);
        check("prio_illegal_pass", p0, 0);

        // pc_x without pc_valid is ignored; with pc_valid it is an event
        do_reset(); start_run();
        pc_valid = 1'b0; pc_x = 1'b1; pc = 32'h100; a0 = 32'hCAFF_E000;
        tick(); tick(); tick();
        check("pcx_invalid_no_done", d0, 0);
        pc_valid = 1'b1;
        tick();
        check("pcx_code", c0, 4);
        check("pcx_pass", p0, 0);

        // Timeout at cycle 49 on u0; u1 never times out
        do_reset(); start_run();
        pc_valid = 1'b1; a0 = 0;
        for (int k = 0; k < 49; k++) begin
            pc = (k % 2 == 0) ? 32'h10 : 32'h14;
            tick();
        end
        check("timeout_pre_done", d0, 0);
        pc = 32'h14;
        tick();
        check("timeout_done", d0, 1);
        check("timeout_code", c0, 5);
        check("timeout_cycles", cy0, 49);
        check("timeout_pulse", dp0, 1);
        check("timeout_dis_early", d1, 0);

        // Both checks disabled on u1: held pc, 10000 cycles, no verdict
        do_reset(); start_run();
        pc_valid = 1'b1; pc = 32'h20;
        seen = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            tick();
            seen = seen | d1;
        end
        check("disabled_never_done", seen, 0);
        check("disabled_cycles", cy1, 10000);
        check("stall_on_u0_meanwhile", c0, 6);

        // Stall on the 9th identical sample
        do_reset(); start_run();
        pc_valid = 1'b1; pc = 32'h20;
        for (int k = 0; k < 8; k++) tick();
        check("stall_pre_done", d0, 0);
        tick();
        check("stall_done", d0, 1);
        check("stall_code", c0, 6);
        check("stall_cycles", cy0, 8);

        // Invalid cycles between samples do not reset the stall count
        do_reset(); start_run();
        pc = 32'h20;
        for (int k = 0; k < 16; k++) begin
            pc_valid = (k % 2 == 0);
            tick();
        end
        check("stall_gap_pre_done", d0, 0);
        pc_valid = 1'b1;
        tick();
        check("stall_gap_code", c0, 6);
        check("stall_gap_cycles", cy0, 16);

        // en dropped mid-RUN, then re-enable and pass
        do_reset(); start_run();
        pc_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            pc = (k % 2 == 0) ? 32'h10 : 32'h14;
            tick();
        end
        check("en_drop_pre_cycles", cy0, 20);
        en = 1'b0;
        tick();
        check("en_drop_cycles", cy0, 0);
        check("en_drop_done", d0, 0);
        en = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            pc = (k % 2 == 0) ? 32'h10 : 32'h14;
            tick();
        end
        pc = 32'h100; a0 = 32'hCAFF_E000;
        tick();
        check("reen_pass", p0, 1);
        check("reen_cycles", cy0, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
